// File: rtl/prog_sequencer.sv
// prog_sequencer
// Run controller that sequences the program counter through one program
// execution: PC reset, entry-address load, free run with branch/jump
// steering, memory-stall freeze, and termination on halt or cycle timeout.
//
// Ports
//   CLK          sole clock, all state on posedge
//   init         synchronous active-high reset (also resets the PC)
//   start        run request level, held high until done is seen
//   prog_sel     program select, sampled in IDLE when start is high
//   pc           current PC value
//   pc_halt      halt flag from the PC
//   mem_busy     datapath stall request
//   br_req       decoder absolute-branch request
//   br_target    branch destination
//   jmp_req      decoder relative-jump request
//   pc_init      PC init
//   pc_branch_en PC branch enable (also used to hold the PC at its value)
//   pc_jump_en   PC relative-jump enable
//   pc_target    PC target, upper 6 bits always zero
//   run          datapath enable
//   done         run complete (registered)
//   timeout      run ended by MAX_CYCLES, valid while done (registered)
//   cycle_count  RUN+STALL cycles of the current/last run (registered)
module prog_sequencer #(
    parameter logic [9:0]  START0     = 10'd0,
    parameter logic [9:0]  START1     = 10'd16,
    parameter logic [9:0]  START2     = 10'd32,
    parameter logic [9:0]  START3     = 10'd48,
    parameter logic [15:0] MAX_CYCLES = 16'd4096
) (
    input  logic        CLK,
    input  logic        init,
    input  logic        start,
    input  logic [1:0]  prog_sel,
    input  logic [9:0]  pc,
    input  logic        pc_halt,
    input  logic        mem_busy,
    input  logic        br_req,
    input  logic [9:0]  br_target,
    input  logic        jmp_req,
    output logic        pc_init,
    output logic        pc_branch_en,
    output logic        pc_jump_en,
    output logic [15:0] pc_target,
    output logic        run,
    output logic        done,
    output logic        timeout,
    output logic [15:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_RUN,
        S_STALL,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic [15:0] cnt_q, cnt_d;

    logic        branch_en_c;
    logic        jump_en_c;
    logic        run_c;
    logic [9:0]  target_c;
    logic        at_limit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [9:0] entry_addr(input logic [1:0] s);
        case (s)
            2'd0:    return START0;
            2'd1:    return START1;
            2'd2:    return START2;
            default: return START3;
        endcase
    endfunction

    assign at_limit = (cnt_q == MAX_CYCLES - 16'd1);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        branch_en_c = 1'b0;
        jump_en_c   = 1'b0;
        run_c       = 1'b0;
        // Branching to the current pc is how the PC is frozen.
        target_c    = pc;

        case (state_q)
            S_IDLE: begin
                branch_en_c = 1'b1;
                if (start) begin
                    sel_d     = prog_sel;
                    cnt_d     = 16'd0;
                    timeout_d = 1'b0;
                    done_d    = 1'b0;
                    state_d   = S_INIT;
                end
            end
            S_INIT: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                branch_en_c = 1'b1;
                target_c    = entry_addr(sel_q);
                state_d     = S_RUN;
            end
            S_RUN: begin
                run_c = 1'b1;
                cnt_d = sat_inc(cnt_q);
                // A stall freezes the PC in the very cycle it is requested.
                if (mem_busy) begin
                    branch_en_c = 1'b1;
                end else if (br_req) begin
                    branch_en_c = 1'b1;
                    target_c    = br_target;
                end else if (jmp_req) begin
                    jump_en_c = 1'b1;
                end
                // Run termination outranks the stall transition; halt outranks timeout.
                if (pc_halt) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                end else if (at_limit) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (mem_busy) begin
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                // The PC stays frozen for every stall cycle, including the one
                // in which mem_busy drops; decoder requests are ignored here.
                branch_en_c = 1'b1;
                cnt_d       = sat_inc(cnt_q);
                if (pc_halt) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                end else if (at_limit) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (!mem_busy) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                branch_en_c = 1'b1;
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (init) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
        sel_q <= sel_d;
    end

    // init resets the PC along with the controller and masks every other control.
    assign pc_init      = init | (state_q == S_INIT);
    assign pc_branch_en = branch_en_c & ~init;
    assign pc_jump_en   = jump_en_c & ~init;
    assign run          = run_c & ~init;
    assign pc_target    = {6'd0, target_c};
    assign done         = done_q;
    assign timeout      = timeout_q;
    assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer
// Drives two prog_sequencer instances (default limit, and MAX_CYCLES=20)
// each attached to a simple behavioural PC. A reference model tracks the
// ideal PC trajectory and cycle count from the run rules: a cycle is a
// stall cycle iff mem_busy was high in the previous run cycle, and the PC
// holds in any stall cycle or any cycle with mem_busy high.
module tb_prog_sequencer;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        init_s      [2];
    logic        start_s     [2];
    logic [1:0]  prog_sel_s  [2];
    logic [9:0]  pc_s        [2] = '{10'd0, 10'd0};
    logic        pc_halt_s   [2];
    logic        mem_busy_s  [2];
    logic        br_req_s    [2];
    logic [9:0]  br_target_s [2];
    logic        jmp_req_s   [2];
    logic        halt_force  [2];
    int          halt_addr   [2];

    logic        pc_init_o   [2];
    logic        br_en_o     [2];
    logic        jmp_en_o    [2];
    logic [15:0] tgt_o       [2];
    logic        run_o       [2];
    logic        done_o      [2];
    logic        to_o        [2];
    logic [15:0] cnt_o       [2];

    int n_vec = 0;
    int n_err = 0;

    prog_sequencer dut0 (
        .CLK(CLK), .init(init_s[0]), .start(start_s[0]), .prog_sel(prog_sel_s[0]),
        .pc(pc_s[0]), .pc_halt(pc_halt_s[0]), .mem_busy(mem_busy_s[0]),
        .br_req(br_req_s[0]), .br_target(br_target_s[0]), .jmp_req(jmp_req_s[0]),
        .pc_init(pc_init_o[0]), .pc_branch_en(br_en_o[0]), .pc_jump_en(jmp_en_o[0]),
        .pc_target(tgt_o[0]), .run(run_o[0]), .done(done_o[0]), .timeout(to_o[0]),
        .cycle_count(cnt_o[0])
    );

    prog_sequencer #(.MAX_CYCLES(16'd20)) dut1 (
        .CLK(CLK), .init(init_s[1]), .start(start_s[1]), .prog_sel(prog_sel_s[1]),
        .pc(pc_s[1]), .pc_halt(pc_halt_s[1]), .mem_busy(mem_busy_s[1]),
        .br_req(br_req_s[1]), .br_target(br_target_s[1]), .jmp_req(jmp_req_s[1]),
        .pc_init(pc_init_o[1]), .pc_branch_en(br_en_o[1]), .pc_jump_en(jmp_en_o[1]),
        .pc_target(tgt_o[1]), .run(run_o[1]), .done(done_o[1]), .timeout(to_o[1]),
        .cycle_count(cnt_o[1])
    );

    assign pc_halt_s[0] = halt_force[0] | (halt_addr[0] >= 0 && int'(pc_s[0]) == halt_addr[0]);
    assign pc_halt_s[1] = halt_force[1] | (halt_addr[1] >= 0 && int'(pc_s[1]) == halt_addr[1]);

    // Behavioural PC: init > branch (absolute) > jump (+4) > increment.
    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (pc_init_o[k])      pc_s[k] <= 10'd0;
            else if (br_en_o[k])   pc_s[k] <= tgt_o[k][9:0];
            else if (jmp_en_o[k])  pc_s[k] <= pc_s[k] + 10'd4;
            else                   pc_s[k] <= pc_s[k] + 10'd1;
        end
    end

    function automatic logic [9:0] entry(input logic [1:0] s);
        case (s)
            2'd0:    return 10'd0;
            2'd1:    return 10'd16;
            2'd2:    return 10'd32;
            default: return 10'd48;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs(input int k);
        mem_busy_s[k]  = 1'b0;
        br_req_s[k]    = 1'b0;
        jmp_req_s[k]   = 1'b0;
        halt_force[k]  = 1'b0;
        br_target_s[k] = 10'd0;
        init_s[k]      = 1'b0;
    endtask

    // One complete run from IDLE. Probabilities are percent per cycle; the
    // pc/count hooks (-1 = unused) place directed events.
    task automatic do_run(input int k, input logic [1:0] sel, input int maxc,
                          input int p_busy, input int p_br, input int p_jmp, input int p_halt,
                          input int halt_at, input int busy_pc, input int busy_len,
                          input int brj_pc, input int brj_tgt, input bit brj_busy,
                          input int loop_pc, input int abort_cnt,
                          output int fin_cnt, output bit fin_to, output int stall_cycles);
        logic [9:0] ref_pc;
        logic [9:0] tgt;
        int  ref_cnt, busy_left;
        bit  stall, ended, exp_to, aborted, hold, busy, br, jmp, hf, ab;
        bit  busy_used, brj_busy_used, brj_taken;
        stall_cycles = 0;
        fin_cnt = 0;
        fin_to = 1'b0;
        start_s[k] = 1'b1;
        prog_sel_s[k] = sel;
        halt_addr[k] = halt_at;
        tick();
        chk("init_pc_init", pc_init_o[k], 1);
        chk("init_done_clr", done_o[k], 0);
        chk("init_cnt_clr", cnt_o[k], 0);
        chk("init_to_clr", to_o[k], 0);
        tick();
        chk("load_br_en", br_en_o[k], 1);
        chk("load_target", tgt_o[k], {6'd0, entry(sel)});
        chk("load_pc_init", pc_init_o[k], 0);
        tick();
        ref_pc = entry(sel);
        ref_cnt = 0; stall = 0; ended = 0; aborted = 0; exp_to = 0;
        busy_left = 0; busy_used = 0; brj_busy_used = 0; brj_taken = 0;
        for (int c = 0; c < 400 && !ended && !aborted; c++) begin
            busy = ($urandom_range(0, 99) < p_busy);
            br   = ($urandom_range(0, 99) < p_br);
            jmp  = ($urandom_range(0, 99) < p_jmp);
            hf   = ($urandom_range(0, 99) < p_halt);
            tgt  = 10'($urandom_range(0, 1023));
            ab   = 0;
            if (busy_pc >= 0 && !busy_used && int'(ref_pc) == busy_pc) begin
                busy_left = busy_len;
                busy_used = 1;
            end
            if (busy_left > 0) begin
                busy = 1;
                busy_left--;
            end
            if (brj_pc >= 0 && !brj_taken && int'(ref_pc) == brj_pc) begin
                br = 1; jmp = 1; tgt = 10'(brj_tgt);
                if (brj_busy && !brj_busy_used) begin
                    busy = 1;
                    brj_busy_used = 1;
                end
            end
            if (loop_pc >= 0 && int'(ref_pc) == loop_pc) begin
                br = 1; tgt = 10'(loop_pc);
            end
            if (abort_cnt >= 0 && ref_cnt == abort_cnt) ab = 1;
            mem_busy_s[k] = busy; br_req_s[k] = br; jmp_req_s[k] = jmp;
            br_target_s[k] = tgt; halt_force[k] = hf; init_s[k] = ab;
            if (ab) start_s[k] = 1'b0;
            #1;
            hold = stall || busy;
            chk("run_pc", pc_s[k], ref_pc);
            chk("run_cnt", cnt_o[k], ref_cnt);
            chk("run_done", done_o[k], 0);
            chk("run_excl", br_en_o[k] & jmp_en_o[k], 0);
            if (ab) begin
                chk("abort_pc_init", pc_init_o[k], 1);
                chk("abort_run", run_o[k], 0);
                chk("abort_br_en", br_en_o[k], 0);
                chk("abort_jmp_en", jmp_en_o[k], 0);
                aborted = 1;
            end else begin
                if (!run_o[k]) stall_cycles++;
                chk("run_en", run_o[k], !stall);
                chk("run_pc_init", pc_init_o[k], 0);
                if (hold) begin
                    chk("hold_br_en", br_en_o[k], 1);
                    chk("hold_jmp_en", jmp_en_o[k], 0);
                    chk("hold_target", tgt_o[k], {6'd0, ref_pc});
                end else if (br) begin
                    chk("br_br_en", br_en_o[k], 1);
                    chk("br_jmp_en", jmp_en_o[k], 0);
                    chk("br_target", tgt_o[k], {6'd0, tgt});
                end else begin
                    chk("plain_br_en", br_en_o[k], 0);
                    chk("plain_jmp_en", jmp_en_o[k], jmp);
                end
                ended  = pc_halt_s[k] || (ref_cnt == maxc - 1);
                exp_to = !pc_halt_s[k] && (ref_cnt == maxc - 1);
                if (!hold && br && brj_pc >= 0 && int'(ref_pc) == brj_pc) brj_taken = 1;
                if (ref_cnt < 65535) ref_cnt++;
                if (hold)      ref_pc = ref_pc;
                else if (br)   ref_pc = tgt;
                else if (jmp)  ref_pc = ref_pc + 10'd4;
                else           ref_pc = ref_pc + 10'd1;
                stall = busy;
            end
            @(posedge CLK);
            #1;
        end
        clear_inputs(k);
        #1;
        if (aborted) begin
            chk("abort_idle_done", done_o[k], 0);
            chk("abort_idle_cnt", cnt_o[k], 0);
            chk("abort_idle_pc", pc_s[k], 0);
            chk("abort_idle_hold", br_en_o[k], 1);
            chk("abort_idle_pc_init", pc_init_o[k], 0);
        end else begin
            n_vec++;
            assert (ended) else begin
                n_err++;
                $error("FAIL run_bound observed=not_ended expected=ended");
            end
            chk("end_done", done_o[k], 1);
            chk("end_timeout", to_o[k], exp_to);
            chk("end_cnt", cnt_o[k], ref_cnt);
            chk("end_pc", pc_s[k], ref_pc);
            fin_cnt = int'(cnt_o[k]);
            fin_to = to_o[k];
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("done_hold_done", done_o[k], 1);
                chk("done_hold_run", run_o[k], 0);
                chk("done_hold_br_en", br_en_o[k], 1);
                chk("done_hold_target", tgt_o[k], {6'd0, pc_s[k]});
                chk("done_hold_pc", pc_s[k], ref_pc);
            end
        end
    endtask

    task automatic finish_run(input int k, input bit exp_done);
        start_s[k] = 1'b0;
        tick();
        chk("idle_done_keep", done_o[k], exp_done);
        chk("idle_pc_init", pc_init_o[k], 0);
        chk("idle_hold", br_en_o[k], 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc, sc;
        bit ft;
        for (int k = 0; k < 2; k++) begin
            clear_inputs(k);
            init_s[k] = 1'b1;
            start_s[k] = 1'b0;
            prog_sel_s[k] = 2'd0;
            halt_addr[k] = -1;
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_pc_init", pc_init_o[k], 1);
            chk("rst_done", done_o[k], 0);
            chk("rst_timeout", to_o[k], 0);
            chk("rst_cnt", cnt_o[k], 0);
            chk("rst_run", run_o[k], 0);
            chk("rst_br_en", br_en_o[k], 0);
            chk("rst_jmp_en", jmp_en_o[k], 0);
            init_s[k] = 1'b0;
        end
        #1;
        chk("idle_hold_after_rst", br_en_o[0], 1);
        chk("idle_pc_init_after_rst", pc_init_o[0], 0);
        tick();
        chk("rst_pc0", pc_s[0], 0);
        chk("rst_pc1", pc_s[1], 0);

        // Program 2 straight through to a halt at pc 65.
        do_run(0, 2'd2, 4096, 0, 0, 0, 0, 65, -1, 0, -1, 0, 0, -1, -1, fc, ft, sc);
        chk("prog2_count", fc, 34);
        chk("prog2_timeout", ft, 0);
        finish_run(0, 1);

        // Three-cycle memory stall at pc 5.
        do_run(0, 2'd0, 4096, 0, 0, 0, 0, 20, 5, 3, -1, 0, 0, -1, -1, fc, ft, sc);
        chk("stall_count", fc, 25);
        chk("stall_run_low_cycles", sc, 3);
        finish_run(0, 1);

        // Branch and jump together at pc 19, first with a stall, then taken.
        do_run(0, 2'd1, 4096, 0, 0, 0, 0, 42, -1, 0, 19, 40, 1, -1, -1, fc, ft, sc);
        chk("brj_count", fc, 9);
        finish_run(0, 1);

        // Infinite self-branch on the 20-cycle instance.
        do_run(1, 2'd3, 20, 0, 0, 0, 0, -1, -1, 0, -1, 0, 0, 50, -1, fc, ft, sc);
        chk("loop_timeout", ft, 1);
        chk("loop_count", fc, 20);
        chk("loop_pc_frozen", pc_s[1], 50);
        finish_run(1, 1);

        // init mid-run at count 7, then a normal run.
        do_run(0, 2'd1, 4096, 0, 0, 0, 0, 100, -1, 0, -1, 0, 0, -1, 7, fc, ft, sc);
        finish_run(0, 0);
        do_run(0, 2'd3, 4096, 0, 0, 0, 0, 60, -1, 0, -1, 0, 0, -1, -1, fc, ft, sc);
        chk("after_abort_count", fc, 13);

        // start held in DONE for 10 more cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("held_done", done_o[0], 1);
            chk("held_no_init", pc_init_o[0], 0);
            chk("held_run", run_o[0], 0);
            chk("held_cnt", cnt_o[0], 13);
        end
        finish_run(0, 1);
        tick();
        chk("idle_done_stays", done_o[0], 1);
        chk("idle_cnt_stays", cnt_o[0], 13);

        // Randomized runs on both instances.
        for (int r = 0; r < 30; r++) begin
            do_run(1, 2'($urandom_range(0, 3)), 20, 25, 10, 15, 6, -1, -1, 0, -1, 0, 0, -1, -1, fc, ft, sc);
            finish_run(1, 1);
        end
        for (int r = 0; r < 8; r++) begin
            do_run(0, 2'($urandom_range(0, 3)), 4096, 20, 10, 15, 5, -1, -1, 0, -1, 0, 0, -1, -1, fc, ft, sc);
            finish_run(0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
